// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the six-digit hex display controller.
// Imported by the controller top and its segment decoder.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

endpackage

// File: rtl/hex_display_ctrl_seg7.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// One instance is time-shared across all digits by the controller.
module seg7_decoder
    import hex_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Six-digit hex display: serial decode into a shadow bank, atomic commit,
// optional leading-zero blanking and a free-running blink overlay.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [23:0] load_data,
    input  logic        lz_blank,
    input  logic        blink_en,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        done
);

    localparam int CW = $clog2(BLINK_DIV);

    state_t      state;
    logic [2:0]  idx;
    logic [23:0] data;
    logic        lzb;
    logic        nz_seen;
    logic [6:0]  shadow [NUM_DIGITS];
    logic [6:0]  disp   [NUM_DIGITS];
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic        blank_digit;
    logic [CW-1:0] cnt;
    logic          phase;

    assign nib = data[{idx, 2'b00} +: 4];

    // Only a zero run starting at the top digit is blanked; digit 0 always shows.
    assign blank_digit = lzb && (idx != 3'd0) && !nz_seen && (nib == 4'h0);

    assign load_ready = (state == IDLE) && !rst;

    seg7_decoder u_dec (
        .nib (nib),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 3'd5;
            data    <= '0;
            lzb     <= 1'b0;
            nz_seen <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= SEG_BLANK;
                disp[i]   <= SEG_BLANK;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        data    <= load_data;
                        lzb     <= lz_blank;
                        idx     <= 3'd5;
                        nz_seen <= 1'b0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    shadow[idx] <= blank_digit ? SEG_BLANK : seg;
                    nz_seen     <= nz_seen | (nib != 4'h0);
                    if (idx == 3'd0) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        disp[i] <= shadow[i];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign HEX0 = phase ? SEG_BLANK : disp[0];
    assign HEX1 = phase ? SEG_BLANK : disp[1];
    assign HEX2 = phase ? SEG_BLANK : disp[2];
    assign HEX3 = phase ? SEG_BLANK : disp[3];
    assign HEX4 = phase ? SEG_BLANK : disp[4];
    assign HEX5 = phase ? SEG_BLANK : disp[5];

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The module SHALL have parameter BLINK_DIV, default 25_000_000, meaning clock cycles per blink half-period (0.5 s at 50 MHz); legal range is 2 or more.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port load_valid, input, 1 bit: the requester offers load_data.
REQ-005 The module SHALL have port load_ready, output, 1 bit: the controller accepts a load this cycle.
REQ-006 The module SHALL have port load_data, input, 24 bits: six hex digits; digit n is bits [4n+3:4n].
REQ-007 The module SHALL have port lz_blank, input, 1 bit: leading-zero blanking request, sampled only at handshake.
REQ-008 The module SHALL have port blink_en, input, 1 bit: live blink enable.
REQ-009 The module SHALL have ports HEX0..HEX5, output, 7 bits each: segment patterns {g,f,e,d,c,b,a}, active low; HEXn shows digit n.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when new HEX content becomes visible.

Function
REQ-011 A transfer SHALL occur on a rising edge where load_valid and load_ready are both 1; load_ready SHALL be 1 exactly when the state is IDLE.
REQ-012 The FSM SHALL have states IDLE, SCAN and COMMIT, with transitions: IDLE->SCAN on transfer; SCAN->SCAN while idx>0; SCAN->COMMIT after idx 0; COMMIT->IDLE unconditionally.
REQ-013 On transfer, the block SHALL latch load_data and lz_blank, set idx=5 and clear the zero-run flag.
REQ-014 Each SCAN cycle SHALL decode one nibble through a single shared decoder instance and write the result to shadow[idx]; idx then decrements (MSB first).
REQ-015 Blanking SHALL apply as follows: if the latched lz_blank is 1, idx is not 0, and all digits above idx plus the current digit are 0, then shadow[idx] SHALL be 7'h7F; digit 0 SHALL never be blanked, so value 0 displays "0".
REQ-016 In COMMIT, all six display registers SHALL load from shadow on the same edge; done SHALL be 1 for exactly the following cycle.
REQ-017 HEX outputs SHALL therefore change exactly 7 edges after the transfer edge; load_ready SHALL reassert in the same cycle done is 1; a new load may be accepted that cycle.
REQ-018 HEX outputs SHALL never show a mix of old and new digits.
REQ-019 load_valid with load_ready at 0 SHALL be ignored; the requester holds the value until accepted.
REQ-020 Blink: while blink_en is 1, a counter SHALL count 0..BLINK_DIV-1 and wrap; at each wrap phase toggles. While phase is 1, all HEXn SHALL be 7'h7F; otherwise HEXn shows its display register.
REQ-021 When blink_en is 0, the counter and phase SHALL be held at 0 (display on); deasserting blink_en SHALL restore the display in the next cycle.
REQ-022 Blink SHALL run independently of the FSM; a COMMIT during the off phase updates the registers while the outputs stay blank.
REQ-023 Decode SHALL follow the standard hex table: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E.

Reset
REQ-024 rst SHALL force: state IDLE, idx 5, display and shadow registers 7'h7F (all off), blink counter 0, phase 0, and done 0.
REQ-025 Reset mid-SCAN or mid-COMMIT SHALL abort the load; no partial commit occurs and the outputs are blank after reset.
REQ-026 load_ready SHALL be 0 while rst is 1 and 1 in the first cycle after release.

Structure
REQ-027 Package hex_disp_pkg SHALL hold: the state enum (IDLE, SCAN, COMMIT), NUM_DIGITS=6 and SEG_BLANK=7'h7F.
REQ-028 Exactly one sub-module SHALL be instantiated: seg7_decoder, once, time-shared across digits.
REQ-029 The implementation SHALL contain no combinational path from load_valid to load_ready.

Verification
REQ-030 The bench SHALL check: load 24'h12AB0F with lz_blank=0 -> after 7 edges HEX5..HEX0 = 79,24,08,03,40,0E; done high for 1 cycle.
REQ-031 The bench SHALL check: load 24'h00_0050 with lz_blank=1 -> HEX5..HEX2 = 7F, HEX1 = 12, HEX0 = 40; load 0 with lz_blank=1 -> only HEX0 = 40.
REQ-032 The bench SHALL check: hold load_valid during SCAN -> load_ready stays 0, no second transfer until the done cycle, then back-to-back acceptance.
REQ-033 The bench SHALL check: BLINK_DIV=4, blink_en=1 -> outputs alternate 4 cycles shown and 4 cycles 7F; blink_en=0 -> shown next cycle.
REQ-034 The bench SHALL check: assert rst on the 3rd SCAN cycle -> all HEX are 7F, no done pulse, load_ready=1 after release.
REQ-035 The bench SHALL check: a load commits during the blink-off phase -> outputs stay 7F until phase 0, then show the new value.
